// File: rtl/dilithium_in_packer.sv
// dilithium_in_packer: packs a frame of host words little-endian into zero-padded core-width words
module dilithium_in_packer #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 64,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len_i,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             m_last,
  output logic             busy,
  output logic             done_o
);
  localparam int RATIO  = OUT_W / IN_W;
  localparam int LANE_W = RATIO > 1 ? $clog2(RATIO) : 1;
  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
  state_t           state;
  logic [LANE_W-1:0] lane;
  logic [LEN_W-1:0] remaining;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] acc_next;
  logic             completing;
  logic             in_hs;
  logic             out_hs;
  logic             last_out;
  assign completing = lane == LANE_W'(RATIO - 1) || remaining == LEN_W'(1);
  assign s_ready    = state == FILL && !(completing && m_valid && !m_ready);
  assign in_hs      = s_valid && s_ready;
  assign out_hs     = m_valid && m_ready;
  assign last_out   = state == DRAIN && out_hs && m_last;
  assign busy       = state != IDLE || m_valid;
  // accumulator with the incoming host word dropped into the current lane; higher lanes are still zero
  always_comb begin
    acc_next = acc;
    acc_next[int'(lane)*IN_W +: IN_W] = s_data;
  end
  // frame control, lane packing and the output register; start always restarts from a clean slate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lane      <= '0;
      remaining <= '0;
      acc       <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
      done_o    <= 1'b0;
    end else if (start) begin
      state     <= len_i != '0 ? FILL : IDLE;
      remaining <= len_i;
      lane      <= '0;
      acc       <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
      done_o    <= len_i == '0;
    end else begin
      done_o <= last_out;
      if (in_hs) begin
        remaining <= remaining - 1'b1;
        lane      <= completing ? '0 : lane + 1'b1;
        acc       <= completing ? '0 : acc_next;
      end
      if (in_hs && completing) begin
        m_valid <= 1'b1;
        m_data  <= acc_next;
        m_last  <= remaining == LEN_W'(1);
      end else if (out_hs) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
      if (in_hs && remaining == LEN_W'(1)) state <= DRAIN;
      else if (last_out) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_dilithium_in_packer.sv
// tb_dilithium_in_packer: table, corner-case and random frame checks against a packing model
module tb_dilithium_in_packer;
  localparam int IN_W  = 32;
  localparam int OUT_W = 64;
  localparam int LEN_W = 16;
  localparam int RATIO = OUT_W / IN_W;
  typedef struct {
    int              len;
    int              mode;
    logic [IN_W-1:0] d[6];
    int              n;
    logic [OUT_W-1:0] e[3];
  } vec_t;
  logic             clk = 1'b0;
  logic             rst;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len_i = '0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [IN_W-1:0]  s_data = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [OUT_W-1:0] m_data;
  logic             m_last;
  logic             busy;
  logic             done_o;
  int               total = 0;
  int               passed = 0;
  logic [IN_W-1:0]  din[$];
  logic [OUT_W-1:0] got_d[$];
  logic             got_l[$];
  vec_t             tbl[3];

  dilithium_in_packer #(.IN_W(IN_W), .OUT_W(OUT_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len_i(len_i),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // packed word i of a frame of len host words held in din: little-endian lanes, missing lanes zero
  function automatic logic [OUT_W-1:0] model_word(input int i, input int len);
    logic [OUT_W-1:0] w;
    w = '0;
    for (int r = 0; r < RATIO; r++)
      if (i * RATIO + r < len) w |= OUT_W'(din[i * RATIO + r]) << (r * IN_W);
    return w;
  endfunction

  // mode 0: m_ready=1, mode 1: m_ready=0 for 5 cycles after the first packed word, mode 2: random valid/ready
  task automatic run_frame(input int len, input int mode);
    int idx, prod, taken, stall;
    logic done_seen, done_pend, prev_hold, prev_last, comp;
    logic [OUT_W-1:0] prev_data;
    idx = 0; prod = 0; taken = 0; stall = 0;
    done_seen = 0; done_pend = 0; prev_hold = 0; prev_last = 0; prev_data = '0;
    got_d.delete();
    got_l.delete();
    @(negedge clk);
    start = 1'b1; len_i = LEN_W'(len); s_valid = 1'b0; m_ready = 1'b0;
    for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      check("done_o", OUT_W'(done_o), OUT_W'(done_pend));
      check("busy", OUT_W'(busy), OUT_W'(!done_pend));
      check("m_valid", OUT_W'(m_valid), OUT_W'(prod > taken));
      if (prev_hold) begin
        check("hold_data", m_data, prev_data);
        check("hold_last", OUT_W'(m_last), OUT_W'(prev_last));
      end
      if (done_o) done_seen = 1'b1;
      s_valid = idx < len && (mode != 2 || $urandom_range(0, 3) != 0);
      s_data  = idx < len ? din[idx] : IN_W'($urandom);
      if (mode == 0) m_ready = 1'b1;
      else if (mode == 1) m_ready = !(prod > 0 && stall < 5);
      else m_ready = 1'($urandom_range(0, 1));
      if (mode == 1 && !m_ready) stall++;
      #1;
      comp = (idx % RATIO == RATIO - 1) || (idx == len - 1);
      check("s_ready", OUT_W'(s_ready), OUT_W'(idx < len && !(comp && prod > taken && !m_ready)));
      done_pend = 1'b0;
      if (m_valid && m_ready) begin
        got_d.push_back(m_data);
        got_l.push_back(m_last);
        taken++;
        if (m_last) done_pend = 1'b1;
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
      if (s_valid && s_ready) begin
        if (comp) prod++;
        idx++;
      end
    end
    if (!done_seen) check("frame_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_model(input int len);
    int n;
    n = (len + RATIO - 1) / RATIO;
    check("out_count", OUT_W'(got_d.size()), OUT_W'(n));
    for (int i = 0; i < n && i < got_d.size(); i++) begin
      check("model_data", got_d[i], model_word(i, len));
      check("model_last", OUT_W'(got_l[i]), OUT_W'(i == n - 1));
    end
  endtask

  task automatic feed_three();
    din.delete();
    @(negedge clk);
    start = 1'b1; len_i = LEN_W'(4); s_valid = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1;
      s_data  = IN_W'($urandom);
      @(negedge clk);
    end
    s_valid = 1'b0;
    #1;
    check("partial_m_valid", OUT_W'(m_valid), OUT_W'(1));
    check("partial_busy", OUT_W'(busy), OUT_W'(1));
  endtask

  initial begin
    rst = 1'b1;
    #1;
    check("rst_s_ready", OUT_W'(s_ready), '0);
    check("rst_m_valid", OUT_W'(m_valid), '0);
    check("rst_m_data", m_data, '0);
    check("rst_m_last", OUT_W'(m_last), '0);
    check("rst_busy", OUT_W'(busy), '0);
    check("rst_done", OUT_W'(done_o), '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    tbl[0].len = 4; tbl[0].mode = 0; tbl[0].n = 2;
    tbl[0].d = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h0, 32'h0};
    tbl[0].e = '{64'h00000022_00000011, 64'h00000044_00000033, 64'h0};
    tbl[1].len = 3; tbl[1].mode = 0; tbl[1].n = 2;
    tbl[1].d = '{32'hA, 32'hB, 32'hC, 32'h0, 32'h0, 32'h0};
    tbl[1].e = '{64'h0000000B_0000000A, 64'h00000000_0000000C, 64'h0};
    tbl[2].len = 6; tbl[2].mode = 1; tbl[2].n = 3;
    tbl[2].d = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6};
    tbl[2].e = '{64'h00000002_00000001, 64'h00000004_00000003, 64'h00000006_00000005};
    for (int t = 0; t < 3; t++) begin
      din.delete();
      for (int k = 0; k < tbl[t].len; k++) din.push_back(tbl[t].d[k]);
      run_frame(tbl[t].len, tbl[t].mode);
      check("tbl_count", OUT_W'(got_d.size()), OUT_W'(tbl[t].n));
      for (int k = 0; k < tbl[t].n && k < got_d.size(); k++) begin
        check("tbl_data", got_d[k], tbl[t].e[k]);
        check("tbl_last", OUT_W'(got_l[k]), OUT_W'(k == tbl[t].n - 1));
      end
    end

    @(negedge clk);
    start = 1'b1; len_i = '0; s_valid = 1'b0; m_ready = 1'b1;
    #1;
    check("len0_busy_pre", OUT_W'(busy), '0);
    @(negedge clk);
    start = 1'b0;
    check("len0_done", OUT_W'(done_o), OUT_W'(1));
    check("len0_m_valid", OUT_W'(m_valid), '0);
    check("len0_busy", OUT_W'(busy), '0);
    @(negedge clk);
    check("len0_done_drop", OUT_W'(done_o), '0);
    check("len0_m_valid2", OUT_W'(m_valid), '0);

    feed_three();
    din.delete();
    for (int k = 0; k < 4; k++) din.push_back(IN_W'($urandom));
    run_frame(4, 0);
    check_model(4);

    feed_three();
    #1 rst = 1'b1;
    #1;
    check("arst_s_ready", OUT_W'(s_ready), '0);
    check("arst_m_valid", OUT_W'(m_valid), '0);
    check("arst_m_data", m_data, '0);
    check("arst_m_last", OUT_W'(m_last), '0);
    check("arst_busy", OUT_W'(busy), '0);
    check("arst_done", OUT_W'(done_o), '0);
    #1 rst = 1'b0;
    din.delete();
    for (int k = 0; k < 5; k++) din.push_back(IN_W'($urandom));
    run_frame(5, 0);
    check_model(5);

    for (int f = 0; f < 20; f++) begin
      int len;
      len = $urandom_range(1, 9);
      din.delete();
      for (int k = 0; k < len; k++) din.push_back(IN_W'($urandom));
      run_frame(len, f % 3);
      check_model(len);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
